// File: rtl/uart_tx_queue_pkg.sv
// rtl/uart_tx_queue_pkg.sv - shared constants for the UART transmit queue
package uart_tx_queue_pkg;

    localparam logic [1:0] TXQ_IDLE      = 2'd0;
    localparam logic [1:0] TXQ_LAUNCH    = 2'd1;
    localparam logic [1:0] TXQ_WAIT_BUSY = 2'd2;
    localparam logic [1:0] TXQ_WAIT_DONE = 2'd3;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

endpackage

// File: rtl/uart_txq_mem.sv
// rtl/uart_txq_mem.sv - queue storage: synchronous write, asynchronous read, no reset
module uart_txq_mem #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and launch FSM feeding the UART transmitter
// Optional XON/XOFF flow control: UART_TXQ_XONXOFF_EN
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  wrEn,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] txData,
    output logic                  txValid,
    input  logic                  txBusy,
    output logic                  txDropped,
    input  logic [DATA_WIDTH-1:0] rxData,
    input  logic                  rxAvailable,
    output logic                  paused
);

    import uart_tx_queue_pkg::*;

    logic [DEPTH_LOG2:0]   r_wptr;
    logic [DEPTH_LOG2:0]   r_rptr;
    logic [1:0]            r_state;
    logic                  r_wait_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_overflow;
    logic                  r_tx_dropped;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_launch;
    logic                  w_paused;

    assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = wrEn & ~w_full & ~flush;
    // A flush in the same cycle must not launch a byte it is discarding.
    assign w_launch = (r_state == TXQ_IDLE) & ~w_empty & ~txBusy & ~w_paused & ~flush;

    uart_txq_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wptr[DEPTH_LOG2-1:0]),
        .i_wr_data (wrData),
        .i_rd_addr (r_rptr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wrEn & w_full & ~flush;
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_launch) begin
                    r_rptr <= r_rptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= TXQ_IDLE;
            r_wait_cnt   <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_dropped <= 1'b0;
        end else begin
            r_tx_valid   <= 1'b0;
            r_tx_dropped <= 1'b0;
            case (r_state)
                TXQ_IDLE: begin
                    if (w_launch) begin
                        r_tx_data  <= w_rd_data;
                        r_tx_valid <= 1'b1;
                        r_state    <= TXQ_LAUNCH;
                    end
                end
                TXQ_LAUNCH: begin
                    r_wait_cnt <= 1'b0;
                    r_state    <= TXQ_WAIT_BUSY;
                end
                TXQ_WAIT_BUSY: begin
                    // Transmitter never went busy (e.g. echo mode): give up after two cycles.
                    if (txBusy) begin
                        r_state <= TXQ_WAIT_DONE;
                    end else if (r_wait_cnt) begin
                        r_tx_dropped <= 1'b1;
                        r_state      <= TXQ_IDLE;
                    end else begin
                        r_wait_cnt <= 1'b1;
                    end
                end
                TXQ_WAIT_DONE: begin
                    if (!txBusy) begin
                        r_state <= TXQ_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef UART_TXQ_XONXOFF_EN
    logic r_paused;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_paused <= 1'b0;
        end else if (rxAvailable) begin
            if (rxData == DATA_WIDTH'(XOFF_CHAR)) begin
                r_paused <= 1'b1;
            end else if (rxData == DATA_WIDTH'(XON_CHAR)) begin
                r_paused <= 1'b0;
            end
        end
    end

    assign w_paused = r_paused;
`else
    logic w_unused_rx;

    assign w_unused_rx = ^{rxData, rxAvailable};
    assign w_paused    = 1'b0;
`endif

    assign full      = w_full;
    assign empty     = w_empty;
    assign level     = r_wptr - r_rptr;
    assign overflow  = r_overflow;
    assign txData    = r_tx_data;
    assign txValid   = r_tx_valid;
    assign txDropped = r_tx_dropped;
    assign paused    = w_paused;

endmodule
